step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Consumes the ~1 Hz slow_clk from clock_divider and turns each rising edge into a one-cycle step event in the clk domain.
//  The step event advances a bounded up/down counter under run/pause/single-step control.
//  Each new count is offered to the downstream display/LED stage over a valid/ready handshake.
//  Sits between clock_divider and the 7-seg/LED driver.
// PARAMETERS
//  WIDTH      8    counter width in bits
//  MAX_COUNT  255  terminal count; legal range 1..2^WIDTH-1
// PORTS
//  clk        in   1      system clock, 100 MHz
//  rst        in   1      synchronous active-low reset; the block resets on a clk rising edge while rst==0
//  slow_clk   in   1      divided clock from clock_divider; used only as data, never as a clock
//  clr        in   1      synchronous clear to IDLE, count=0
//  start      in   1      level; IDLE/PAUSE -> RUN
//  pause      in   1      level; RUN -> PAUSE
//  step       in   1      single-cycle pulse; one advance while in PAUSE
//  dir        in   1      1=up, 0=down; sampled when an advance occurs
//  count      out  WIDTH  current count
//  tick       out  1      one-cycle pulse in the cycle after each advance (i.e. together with the new count)
//  wrap       out  1      one-cycle pulse, coincident with tick, when the advance wrapped
//  state      out  2      IDLE=2'd0, RUN=2'd1, PAUSE=2'd2 (2'd3 unused; decodes to IDLE)
//  out_valid  out  1      a new count is pending for downstream
//  out_ready  in   1      downstream accepts the pending count
//  overrun    out  1      sticky: a count update occurred while the previous one was still unaccepted
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): count=0, state=IDLE, tick=0, wrap=0, out_valid=0, overrun=0, edge/sync regs=0.
//  Edge detect: slow_edge = s & ~s_d, where s is slow_clk (optionally synchronised) and s_d is s delayed 1 clk.
//    - An edge present at reset release is harmless: state is IDLE, so no advance occurs.
//  FSM, evaluated every clk. Priority order: clr > pause > start.
//    - clr: next state IDLE; count<=0; out_valid<=0; overrun unchanged.
//    - IDLE: start -> RUN. slow_edge and step are ignored.
//    - RUN: pause -> PAUSE. Otherwise slow_edge -> advance.
//    - PAUSE: start -> RUN. Otherwise step -> advance. slow_edge is ignored.
//    - An advance occurs only in a cycle where state is already RUN (edge) or PAUSE (step).
//      A transitioning input wins: pause together with an edge gives no advance; start in IDLE together with an edge gives no advance.
//    - step asserted in RUN or IDLE is ignored.
//  Advance arithmetic:
//    - Up: count==MAX_COUNT -> 0 with wrap; otherwise count+1.
//    - Down: count==0 -> MAX_COUNT with wrap; otherwise count-1.
//    - Count never leaves 0..MAX_COUNT.
//  Latency: count, tick and wrap update on the clk edge following the cycle in which slow_edge (or step) is seen.
//  Handshake:
//    - Each advance sets out_valid<=1.
//    - out_valid clears on the edge where out_valid && out_ready, unless an advance occurs in the same cycle; then it stays 1.
//    - An advance while out_valid && !out_ready sets overrun<=1. overrun clears only on reset.
//    - Counting never stalls on out_ready. count always shows the latest value, whether or not it has been accepted.
//  Reset mid-operation: all state is discarded immediately and no pulse is emitted.
//    A slow_clk edge arriving in the first cycle after reset release is not counted.
// CONFIGURATION
//  TICK_SYNC_EN defined:
//    - slow_clk passes through a 2-FF synchroniser before edge detect.
//    - slow_clk rise to count update = 3 clk.
//    - For use when slow_clk comes from a foreign domain or a pin.
//  TICK_SYNC_EN undefined:
//    - slow_clk is sampled directly; rise to count update = 1 clk.
//    - Legal only when slow_clk is registered on clk, as clock_divider's output is.
// TESTING
//  1. Reset, start=1, dir=1, 3 slow_clk rises -> count 0->1->2->3; 3 tick pulses, each 1 clk wide; wrap=0.
//  2. MAX_COUNT=5, count=5, dir=1, edge -> count=0, wrap=1 for 1 clk. Then dir=0, edge -> count=5, wrap=1.
//  3. RUN, assert pause in the same cycle as slow_edge -> no advance, state=PAUSE. Then 2 step pulses -> count +2.
//     Edges while in PAUSE leave count unchanged.
//  4. out_ready=0 across 2 advances -> out_valid stays 1, overrun=1. Then out_ready=1 -> out_valid=0 next clk; overrun stays 1.
//  5. rst=0 for 1 clk mid-RUN with count=7 -> count=0, state=IDLE, out_valid=0.
//     clr in RUN -> IDLE, count=0, overrun unchanged.
//  6. Run cases 1 and 3 with and without TICK_SYNC_EN -> rise-to-update latency of 3 vs 1 clk respectively.

Source files
------------

// File: rtl/step_sequencer.sv
// Step sequencer: turns slow_clk rising edges into bounded up/down count advances under run/pause/step control,
// with a valid/ready output handshake. Define TICK_SYNC_EN to pass slow_clk through a 2-FF synchroniser first.
module step_sequencer #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             clr,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic [1:0]       state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic s_cur;
    logic s_d_q;
    logic slow_edge;

`ifdef TICK_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= slow_clk;
            sync2_q <= sync1_q;
        end
    end

    assign s_cur = sync2_q;
`else
    // slow_clk is already registered on clk by the divider, so it is sampled directly.
    assign s_cur = slow_clk;
`endif

    always_ff @(posedge clk) begin
        if (!rst) s_d_q <= 1'b0;
        else      s_d_q <= s_cur;
    end

    assign slow_edge = s_cur & ~s_d_q;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             advance;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = overrun_q;
        advance     = 1'b0;

        if (clr) begin
            state_d     = IDLE;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            // A state transition always wins over an advance in the same cycle.
            case (state_q)
                IDLE: begin
                    if (start && !pause) state_d = RUN;
                end
                RUN: begin
                    if (pause)          state_d = PAUSE;
                    else if (slow_edge) advance = 1'b1;
                end
                PAUSE: begin
                    if (start && !pause) state_d = RUN;
                    else if (step)       advance = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (advance) begin
            tick_d      = 1'b1;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) overrun_d = 1'b1;
            if (dir) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    assign count     = count_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign state     = state_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer (MAX_COUNT=5): stimulus pushes expected tick results, a monitor pops and checks them.
module tb_step_sequencer;

`ifdef TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, slow_clk, clr, start, pause, step, dir, out_ready;
    logic [7:0] count;
    logic       tick, wrap, out_valid, overrun;
    logic [1:0] state;

    always #5 clk = ~clk;

    step_sequencer #(.WIDTH(8), .MAX_COUNT(5)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .clr(clr), .start(start),
        .pause(pause), .step(step), .dir(dir), .count(count), .tick(tick),
        .wrap(wrap), .state(state), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       wr;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic w, input int l);
        exp_t e;
        e.cnt = c; e.wr = w; e.lat = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every tick must match the oldest expected advance.
    always @(negedge clk) begin
        if (rst && tick) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tick: got count=%0d wrap=%0d, expected no tick", count, wrap);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("tick: count=%0d wrap=%0d latency=%0d", count, wrap, cyc - rise_cyc);
                chk("tick_count", 32'(count), 32'(e.cnt));
                chk("tick_wrap", 32'(wrap), 32'(e.wr));
                chk("tick_out_valid", 32'(out_valid), 32'd1);
                if (e.lat > 0) chk("tick_latency", 32'(cyc - rise_cyc), 32'(e.lat));
            end
        end else if (rst && wrap) begin
            checks++; errors++;
            $display("FAIL wrap_without_tick: got wrap=1, expected 0");
        end
    end

    task automatic slow_pulse();
        @(posedge clk); #1 slow_clk = 1'b1; rise_cyc = cyc;
        repeat (4) @(posedge clk);
        #1 slow_clk = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic step_pulse();
        @(posedge clk); #1 step = 1'b1; rise_cyc = cyc;
        @(posedge clk); #1 step = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; slow_clk = 1'b0; clr = 1'b0; start = 1'b0; pause = 1'b0;
        step = 1'b0; dir = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_count", 32'(count), 0);
        chk("reset_state", 32'(state), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_overrun", 32'(overrun), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Edges in IDLE are ignored
        slow_pulse();
        @(negedge clk) chk("idle_edge_count", 32'(count), 0);

        // Case 1: count up 1,2,3
        start_pulse();
        @(negedge clk) chk("run_state", 32'(state), 1);
        for (int i = 1; i <= 3; i++) begin
            push(8'(i), 1'b0, LAT);
            slow_pulse();
        end
        @(negedge clk) chk("case1_count", 32'(count), 3);

        // Case 2: wrap up at MAX_COUNT, wrap down at 0
        push(8'd4, 1'b0, LAT); slow_pulse();
        push(8'd5, 1'b0, LAT); slow_pulse();
        push(8'd0, 1'b1, LAT); slow_pulse();
        dir = 1'b0;
        push(8'd5, 1'b1, LAT); slow_pulse();
        push(8'd4, 1'b0, LAT); slow_pulse();
        push(8'd3, 1'b0, LAT); slow_pulse();
        @(negedge clk) chk("case2_count", 32'(count), 3);

        // Case 3: pause coincident with slow_edge gives no advance
        @(posedge clk); #1 slow_clk = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 pause = 1'b1;
        @(posedge clk); #1 pause = 1'b0;
        repeat (3) @(posedge clk);
        #1 slow_clk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pause_state", 32'(state), 2);
        chk("pause_edge_count", 32'(count), 3);
        dir = 1'b1;
        push(8'd4, 1'b0, 1); step_pulse();
        push(8'd5, 1'b0, 1); step_pulse();
        slow_pulse();
        @(negedge clk) chk("pause_ignores_edge", 32'(count), 5);

        // Case 4: unaccepted updates set overrun
        start_pulse();
        @(negedge clk) chk("pre_overrun_valid", 32'(out_valid), 0);
        out_ready = 1'b0;
        push(8'd0, 1'b1, LAT); slow_pulse();
        @(negedge clk) chk("first_unacked_overrun", 32'(overrun), 0);
        push(8'd1, 1'b0, LAT); slow_pulse();
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 1);
        chk("valid_held", 32'(out_valid), 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk) chk("valid_before_accept_edge", 32'(out_valid), 1);
        @(negedge clk);
        chk("valid_cleared", 32'(out_valid), 0);
        chk("overrun_sticky", 32'(overrun), 1);

        // step while running is ignored
        step_pulse();
        @(negedge clk) chk("run_step_ignored", 32'(count), 1);

        // Case 5: reset mid-run, then clr mid-run
        push(8'd2, 1'b0, LAT); slow_pulse();
        push(8'd3, 1'b0, LAT); slow_pulse();
        push(8'd4, 1'b0, LAT); slow_pulse();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        start_pulse();
        out_ready = 1'b0;
        push(8'd1, 1'b0, LAT); slow_pulse();
        push(8'd2, 1'b0, LAT); slow_pulse();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_state", 32'(state), 0);
        chk("clr_count", 32'(count), 0);
        chk("clr_out_valid", 32'(out_valid), 0);
        chk("clr_overrun_kept", 32'(overrun), 1);
        slow_pulse();
        @(negedge clk) chk("post_clr_idle_count", 32'(count), 0);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
